// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and peripheral constants.
// Build option: UART_RX_PARITY_EN adds the even-parity state (8E1 frames instead of 8N1).
package uart_rx_fifo_pkg;

  localparam int unsigned UART_CLK_FREQ   = 50_000_000;
  localparam int unsigned UART_BAUD       = 115_200;
  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam logic [31:0] UART_BASE       = 32'h1000_0000;
  localparam logic [31:0] UART_DATA_OFF   = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is still accepted.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding an MMIO-readable FWFT FIFO.
// Sticky frame_err/overrun flags clear on clr_err, with a coincident set taking priority.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
  parameter int unsigned BAUD       = UART_BAUD,
  parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          clr_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  uart_rx_state_t   r_state, w_state_d;
  logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_d;
  logic [2:0]       r_bit_cnt, w_bit_cnt_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_push, w_push_d;
  logic             w_frame_set;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic             r_frame_err, r_overrun;
  logic             w_fifo_empty, w_fifo_full, w_drop;
  logic             w_stop_ok;
`ifdef UART_RX_PARITY_EN
  logic             r_par_ok, w_par_ok_d;
  assign w_stop_ok = r_rx_sync && r_par_ok;
`else
  assign w_stop_ok = r_rx_sync;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt + 1'b1;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_push_d    = 1'b0;
    w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_ok_d  = r_par_ok;
`endif
    unique case (r_state)
      StIdle: begin
        w_clk_cnt_d = '0;
        if (r_rx_prev && !r_rx_sync) begin
          w_state_d   = StStart;
          w_bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_d = '0;
          w_state_d   = r_rx_sync ? StIdle : StData;
        end
      end
      StData: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          w_shift_d   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_d = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          w_par_ok_d  = ~(^{r_shift, r_rx_sync});
          w_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          w_state_d   = StIdle;
          w_push_d    = w_stop_ok;
          w_frame_set = !w_stop_ok;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Byte is lost only when full and no read frees a slot in the same cycle.
  assign w_drop = r_push && w_fifo_full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= StIdle;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok    <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_push    <= w_push_d;
`ifdef UART_RX_PARITY_EN
      r_par_ok  <= w_par_ok_d;
`endif
      if (w_frame_set)  r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
      if (w_drop)       r_overrun   <= 1'b1;
      else if (clr_err) r_overrun   <= 1'b0;
    end
  end

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_push),
    .i_data  (r_shift),
    .i_pop   (rd_en),
    .o_data  (rd_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (rx_count)
  );

  assign rx_valid  = !w_fifo_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en, input, 1, MMIO read strobe of the UART data register at offset 0x0; pops one byte.
REQ-008 SHALL have port rd_data, output, 8, FIFO head byte, first-word-fall-through.
REQ-009 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-010 SHALL have port rx_count, output, $clog2(FIFO_DEPTH)+1, bytes held.
REQ-011 SHALL have port clr_err, input, 1, clears the sticky error flags.
REQ-012 SHALL have port frame_err, output, 1, sticky flag: a stop bit was sampled low.
REQ-013 SHALL have port overrun, output, 1, sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer, both flops reset to 1; the FSM uses only the synchronized value.
REQ-015 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division) and HALF_BIT = CLKS_PER_BIT/2.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; reset state is IDLE.
REQ-017 IDLE: on a synchronized 1->0 transition, SHALL go to START and clear the bit counter.
REQ-018 START: after HALF_BIT clocks, SHALL resample the line; low goes to DATA, high (glitch) returns to IDLE with no flag set.
REQ-019 DATA: SHALL sample every CLKS_PER_BIT clocks, shift in LSB first, and after 8 bits go to PARITY if enabled, else STOP.
REQ-020 STOP: after CLKS_PER_BIT clocks, SHALL sample; high means push the byte, low means discard it and set frame_err; either way return to IDLE.
REQ-021 SHALL assert the FIFO push for exactly one cycle per accepted byte, in the cycle after the stop sample.
REQ-022 Push while full with no pop in the same cycle SHALL drop the new byte, keep FIFO contents, and set overrun.
REQ-023 Push and pop in the same cycle SHALL both take effect, including when full or holding one entry; rx_count is unchanged.
REQ-024 rd_en while empty SHALL be ignored; rd_data SHALL read 8'h00 whenever the FIFO is empty.
REQ-025 rd_data SHALL reflect the new head in the cycle after a pop.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer MSB.
REQ-027 Sticky flags SHALL clear on clr_err; if a set event coincides with clr_err, set wins.

Reset
REQ-028 rst SHALL force: FSM to IDLE, counters to 0, FIFO empty, rx_valid=0, rx_count=0, rd_data=0, frame_err=0, overrun=0, synchronizer=1.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no push; the receiver resynchronizes on the next falling edge after release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: SHALL enable the PARITY state, sampled CLKS_PER_BIT after the last data bit; even parity is checked.
REQ-031 With UART_RX_PARITY_EN, a parity mismatch SHALL discard the byte and set frame_err.
REQ-032 Macro UART_RX_PARITY_EN undefined: SHALL contain no PARITY state or parity logic; frames are 8N1.

Structure
REQ-033 The peripheral package SHALL hold the FSM state enum uart_rx_state_t, default UART_BAUD, and UART_FIFO_DEPTH alongside UART_BASE/UART_DATA_OFF.
REQ-034 The FIFO SHALL be a separate sub-module uart_fifo (sync, FWFT, parameterized width/depth) instanced once; the FSM stays in uart_rx_fifo.

Verification (CLK_FREQ=50e6, BAUD=115200, CLKS_PER_BIT=434)
REQ-035 Send 8'hA5 as 8N1 -> rx_valid rises; rd_data=8'hA5; rd_en pulse -> rx_valid=0, rd_data=8'h00.
REQ-036 Low glitch of 100 clocks on idle line -> no push; frame_err=0; FSM back in IDLE.
REQ-037 Send 8'h3C with stop bit held low -> no push; frame_err=1; clr_err pulse -> frame_err=0.
REQ-038 Send 17 bytes 8'h00..8'h10 with no reads -> rx_count=16; overrun=1; reads return 8'h00..8'h0F in order.
REQ-039 FIFO full, rd_en coincident with push of 8'h55 -> rx_count stays 16; overrun=0; 8'h55 is read last.
REQ-040 Assert rst during bit 4 of 8'hFF, then send 8'h81 -> only 8'h81 is received.
